muldiv_hilo_unit: RTL and testbench

Parametrised iterative multiply/divide engine with architectural HI/LO registers for the execute stage of the pipelined MIPS32 core. It supersedes the single-width mul/div block plus separate high/low registers and ad-hoc read-done qualification. It adds:
- signed/unsigned modes
- a start/busy/done handshake
- direct HI/LO writes (MTHI/MTLO)
- a stall output that the hazard logic uses to freeze the front of the pipeline while a HI/LO access must wait.

---
 rtl/muldiv_hilo_unit.sv | 182 ++++++++++++++++++
 tb/tb_muldiv_hilo_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide engine with architectural HI/LO registers.
// MULT/MULTU use radix-2 shift-add; DIV/DIVU use radix-2 restoring division.
// Both run on operand magnitudes, and the sign is fixed up in a final cycle.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes accepted
// RUN   | WIDTH iterations, counter WIDTH-1 down to 0
// FIX   | sign correction, HI/LO load, done pulse next cycle
module muldiv_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hilo_wr,
  input  logic             wr_hi0_lo1,
  input  logic [WIDTH-1:0] wd,
  input  logic             rd_req,
  input  logic             rd_hi0_lo1,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic               rem_ge;
  logic               neg_res;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;

  // Operand magnitudes, one iteration step for each datapath, and the final sign fix.
  always_comb begin
    a_mag    = (op[0] && a[WIDTH-1]) ? -a : a;
    b_mag    = (op[0] && b[WIDTH-1]) ? -b : b;
    mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opb_q} : '0);
    // The trial subtraction is one bit wider than the remainder, so its top bit is the borrow.
    rem_sh   = {rem_q, prod_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opb_q};
    rem_ge   = ~rem_diff[WIDTH];
    neg_res  = op_q[0] & (sa_q ^ sb_q);
    quot_fix = neg_res ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
    rem_fix  = (op_q[0] && sa_q) ? -rem_q : rem_q;
    prod_fix = neg_res ? -prod_q : prod_q;
  end

  // Next-state logic and datapath updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    opb_d   = opb_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = CW'(WIDTH - 1);
          op_d    = op;
          sa_d    = op[0] & a[WIDTH-1];
          sb_d    = op[0] & b[WIDTH-1];
          dz_d    = op[1] & (b == '0);
          rem_d   = '0;
          if (op[1]) begin
            opb_d  = b_mag;
            prod_d = {{WIDTH{1'b0}}, a_mag};
          end else begin
            opb_d  = a_mag;
            prod_d = {{WIDTH{1'b0}}, b_mag};
          end
        end
        // A write taken alongside a start is later overwritten by the result.
        if (hilo_wr) begin
          if (wr_hi0_lo1) lo_d = wd;
          else            hi_d = wd;
        end
      end
      S_RUN: begin
        if (op_q[1]) begin
          // The low half shifts the dividend out and the quotient bits in.
          if (rem_ge) begin
            rem_d  = rem_diff[WIDTH-1:0];
            prod_d = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d  = rem_sh[WIDTH-1:0];
            prod_d = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          prod_d = {mul_sum, prod_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (op_q[1]) begin
          lo_d = quot_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      opb_q   <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      opb_q   <= opb_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  // Outputs: the read port is a plain mux on the registers.
  always_comb begin
    busy     = (state_q != S_IDLE);
    stall    = busy & (start | rd_req | hilo_wr);
    rdata    = rd_hi0_lo1 ? lo_q : hi_q;
    done     = done_q;
    div_zero = dz_q;
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard testbench for muldiv_hilo_unit (WIDTH = 32).
module tb_muldiv_hilo_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         hilo_wr = 1'b0;
  logic         wr_hi0_lo1 = 1'b0;
  logic [W-1:0] wd = '0;
  logic         rd_req = 1'b0;
  logic         rd_hi0_lo1 = 1'b0;
  logic [W-1:0] rdata;
  logic         busy, done, stall, div_zero;

  int n_checks = 0;
  int n_fail   = 0;

  logic [64:0] exp_q[$];

  muldiv_hilo_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hilo_wr(hilo_wr), .wr_hi0_lo1(wr_hi0_lo1), .wd(wd),
    .rd_req(rd_req), .rd_hi0_lo1(rd_hi0_lo1), .rdata(rdata),
    .busy(busy), .done(done), .stall(stall), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Reference model: returns {div_zero, HI, LO}.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] p;
    longint px, py, q, r;
    logic [W-1:0] hi, lo;
    px = longint'($signed(x));
    py = longint'($signed(y));
    hi = '0;
    lo = '0;
    case (o)
      2'b00: begin p = {32'b0, x} * {32'b0, y}; hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin q = px * py; hi = q[63:32]; lo = q[31:0]; end
      2'b10: begin
        if (y == '0) begin hi = x; lo = '1; end
        else begin lo = x / y; hi = x % y; end
      end
      default: begin
        if (y == '0) begin hi = x; lo = x[W-1] ? 32'h1 : 32'hFFFF_FFFF; end
        else begin q = px / py; r = px % py; lo = q[31:0]; hi = r[31:0]; end
      end
    endcase
    return {(o[1] && y == '0), hi, lo};
  endfunction

  // Issue one operation, apply per-cycle hazards while busy, then check the scoreboard entry.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input bit rd_every, input int restart_at, input int wr_at,
                        input bit wr_with_start, input logic [W-1:0] wdv, input logic [W-1:0] hi_before_in);
    logic [64:0]  e;
    logic [W-1:0] hi_before;
    int cyc;
    hi_before = hi_before_in;
    rd_hi0_lo1 = 1'b0;
    op = o; a = oa; b = ob; start = 1'b1;
    exp_q.push_back(model(o, oa, ob));
    if (wr_with_start) begin hilo_wr = 1'b1; wr_hi0_lo1 = 1'b0; wd = wdv; end
    @(posedge clk); #1;
    start = 1'b0; hilo_wr = 1'b0;
    if (wr_with_start) begin
      n_checks++;
      if (rdata !== wdv) begin n_fail++; $display("FAIL wr_with_start_hi: got %h expected %h", rdata, wdv); end
      hi_before = wdv;
    end
    cyc = 0;
    while (busy === 1'b1 && cyc < 2*W + 4) begin
      rd_req = rd_every; rd_hi0_lo1 = rd_every;
      start = (cyc == restart_at);
      if (cyc == restart_at) begin op = 2'b10; a = 32'd9; b = 32'd0; end
      hilo_wr = (cyc == wr_at); wr_hi0_lo1 = 1'b0; wd = 32'hDEAD_BEEF;
      #1;
      n_checks++;
      if (stall !== (rd_every || cyc == restart_at || cyc == wr_at)) begin
        n_fail++; $display("FAIL stall_cycle_%0d: got %b expected %b", cyc, stall, (rd_every || cyc == restart_at || cyc == wr_at));
      end
      if (wr_at >= 0) begin
        n_checks++;
        if (rdata !== hi_before) begin n_fail++; $display("FAIL hi_hold_cycle_%0d: got %h expected %h", cyc, rdata, hi_before); end
      end
      cyc++;
      @(posedge clk); #1;
    end
    start = 1'b0; hilo_wr = 1'b0;
    n_checks++;
    if (cyc !== W + 1) begin n_fail++; $display("FAIL busy_cycles: got %0d expected %0d", cyc, W + 1); end
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL done_pulse: got %b expected 1", done); end
    e = exp_q.pop_front();
    if (rd_every) begin
      n_checks++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL idle_read_stall: got %b expected 0", stall); end
      n_checks++;
      if (rdata !== e[31:0]) begin n_fail++; $display("FAIL idle_read_lo: got %h expected %h", rdata, e[31:0]); end
    end
    rd_req = 1'b0; rd_hi0_lo1 = 1'b0;
    #1;
    n_checks++;
    if (rdata !== e[63:32]) begin n_fail++; $display("FAIL hi op=%0d a=%h b=%h: got %h expected %h", o, oa, ob, rdata, e[63:32]); end
    rd_hi0_lo1 = 1'b1;
    #1;
    n_checks++;
    if (rdata !== e[31:0]) begin n_fail++; $display("FAIL lo op=%0d a=%h b=%h: got %h expected %h", o, oa, ob, rdata, e[31:0]); end
    n_checks++;
    if (div_zero !== e[64]) begin n_fail++; $display("FAIL div_zero op=%0d b=%h: got %b expected %b", o, ob, div_zero, e[64]); end
  endtask

  task automatic test_reset();
    start = 1'b1; op = 2'b10; b = '0; rd_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (stall !== 1'b0)    begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_div_zero: got %b expected 0", div_zero); end
    rd_hi0_lo1 = 1'b0; #1;
    n_checks++; if (rdata !== '0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", rdata); end
    rd_hi0_lo1 = 1'b1; #1;
    n_checks++; if (rdata !== '0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", rdata); end
    start = 1'b0; rd_req = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_multu_max();
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, -1, 1'b0, '0, '0);
    rd_hi0_lo1 = 1'b0; #1;
    n_checks++; if (rdata !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_max_hi: got %h expected fffffffe", rdata); end
    rd_hi0_lo1 = 1'b1; #1;
    n_checks++; if (rdata !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_max_lo: got %h expected 00000001", rdata); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_width: got %b expected 0", done); end
  endtask

  task automatic test_mthi_mtlo();
    hilo_wr = 1'b1; wr_hi0_lo1 = 1'b0; wd = 32'h0000_1234; rd_hi0_lo1 = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mthi_stall: got %b expected 0", stall); end
    n_checks++; if (rdata !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mthi_same_cycle_read: got %h expected fffffffe", rdata); end
    @(posedge clk); #1;
    wr_hi0_lo1 = 1'b1; wd = 32'h0000_5678; rd_hi0_lo1 = 1'b0;
    #1;
    n_checks++; if (rdata !== 32'h0000_1234) begin n_fail++; $display("FAIL mthi_value: got %h expected 00001234", rdata); end
    @(posedge clk); #1;
    hilo_wr = 1'b0; rd_hi0_lo1 = 1'b1; #1;
    n_checks++; if (rdata !== 32'h0000_5678) begin n_fail++; $display("FAIL mtlo_value: got %h expected 00005678", rdata); end
    rd_hi0_lo1 = 1'b0; #1;
    n_checks++; if (rdata !== 32'h0000_1234) begin n_fail++; $display("FAIL mtlo_hi_kept: got %h expected 00001234", rdata); end
  endtask

  task automatic test_start_with_wr();
    run_op(2'b00, 32'd2, 32'd3, 1'b0, -1, -1, 1'b1, 32'h0000_ABCD, '0);
  endtask

  task automatic test_signed();
    logic [1:0]   o;
    logic [W-1:0] x, y;
    run_op(2'b01, -32'sd3, 32'd7, 1'b0, -1, -1, 1'b0, '0, '0);
    run_op(2'b11, -32'sd7, 32'd2, 1'b0, -1, -1, 1'b0, '0, '0);
    run_op(2'b10, 32'd100, 32'd7, 1'b0, -1, -1, 1'b0, '0, '0);
    run_op(2'b11, 32'd7, -32'sd2, 1'b0, -1, -1, 1'b0, '0, '0);
    for (int i = 0; i < 6; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      if (i[0]) y = y >> $urandom_range(0, 28);
      if (y == '0) y = 32'd1;
      run_op(o, x, y, 1'b0, -1, -1, 1'b0, '0, '0);
    end
  endtask

  task automatic test_corner_div();
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, -1, 1'b0, '0, '0);
    run_op(2'b10, 32'd5, 32'd0, 1'b0, -1, -1, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (div_zero !== 1'b1) begin n_fail++; $display("FAIL div_zero_sticky: got %b expected 1", div_zero); end
    run_op(2'b11, -32'sd9, 32'd0, 1'b0, -1, -1, 1'b0, '0, '0);
    run_op(2'b00, 32'd11, 32'd0, 1'b0, -1, -1, 1'b0, '0, '0);
  endtask

  task automatic test_hazards();
    logic [64:0] prev;
    run_op(2'b01, 32'd1234567, -32'sd89, 1'b1, -1, -1, 1'b0, '0, '0);
    run_op(2'b01, -32'sd40000, -32'sd70000, 1'b0, 10, -1, 1'b0, '0, '0);
    prev = model(2'b01, -32'sd40000, -32'sd70000);
    run_op(2'b01, 32'd77, -32'sd5, 1'b0, -1, 5, 1'b0, '0, prev[63:32]);
  endtask

  task automatic test_back_to_back();
    run_op(2'b10, 32'hFFFF_FFFF, 32'd3, 1'b0, -1, -1, 1'b0, '0, '0);
    run_op(2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, -1, -1, 1'b0, '0, '0);
    run_op(2'b11, 32'h8000_0000, 32'd1, 1'b0, -1, -1, 1'b0, '0, '0);
  endtask

  task automatic test_async_reset();
    int bad;
    op = 2'b11; a = -32'sd100; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rd_req = 1'b1;
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL areset_busy: got %b expected 0", busy); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL areset_stall: got %b expected 0", stall); end
    rd_hi0_lo1 = 1'b0; #1;
    n_checks++; if (rdata !== '0) begin n_fail++; $display("FAIL areset_hi: got %h expected 0", rdata); end
    rd_hi0_lo1 = 1'b1; #1;
    n_checks++; if (rdata !== '0) begin n_fail++; $display("FAIL areset_lo: got %h expected 0", rdata); end
    rd_req = 1'b0;
    @(negedge clk); rst = 1'b1;
    bad = 0;
    for (int i = 0; i < W + 6; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL areset_no_done: got %0d active cycles expected 0", bad); end
    run_op(2'b11, -32'sd100, 32'd3, 1'b0, -1, -1, 1'b0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_mthi_mtlo();
    test_start_with_wr();
    test_signed();
    test_corner_div();
    test_hazards();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
